// File: rtl/rv_pkg.sv
// Shared RV32I integer-register definitions: widths, ABI register indices and
// architectural reset values used by the register file and its neighbours.
package rv_pkg;

  localparam int unsigned XLEN           = 32;
  localparam int unsigned REG_ADDR_WIDTH = 5;

  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned REG_SP   = 2;
  localparam int unsigned REG_GP   = 3;

  localparam logic [XLEN-1:0] SP_INIT = 32'h0000_0200;
  localparam logic [XLEN-1:0] GP_INIT = 32'h0000_0100;

  typedef logic [XLEN-1:0]           xlen_t;
  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write tracker: issue marks a destination pending,
// writeback retires it, flush drops everything; busy lookup per read port.
module regfile_scoreboard
  import rv_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned AW       = $clog2(NUM_REGS),
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic                 sb_set,
  input  logic [AW-1:0]        sb_addr,
  input  logic                 sb_flush,
  input  logic [NUM_RD*AW-1:0] rs_addr,
  output logic [NUM_RD-1:0]    rs_busy
);

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_nxt;

  // Retire first so a new producer on the same register re-marks it; flush beats both.
  always_comb begin
    pending_nxt = pending;
    if (wr_en && (wr_addr != AW'(REG_ZERO))) begin
      pending_nxt[wr_addr] = 1'b0;
    end
    if (sb_set && (sb_addr != AW'(REG_ZERO))) begin
      pending_nxt[sb_addr] = 1'b1;
    end
    if (sb_flush) begin
      pending_nxt = '0;
    end
    pending_nxt[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  // A register being written this cycle is not a hazard when its data is forwarded.
  for (genvar i = 0; i < NUM_RD; i++) begin : g_busy
    logic [AW-1:0] rd_addr;
    logic          fwd;

    assign rd_addr    = rs_addr[i*AW +: AW];
    assign fwd        = (BYPASS != 0) && wr_en && (wr_addr == rd_addr);
    assign rs_busy[i] = pending[rd_addr] && (rd_addr != AW'(REG_ZERO)) && !fwd;
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port RV32I integer register file with optional write-to-read
// bypass and a pending-write scoreboard for RAW hazard detection.
module regfile_mp
  import rv_pkg::*;
#(
  parameter int unsigned     XLEN     = rv_pkg::XLEN,
  parameter int unsigned     NUM_REGS = 32,
  parameter int unsigned     AW       = $clog2(NUM_REGS),
  parameter int unsigned     NUM_RD   = 2,
  parameter int unsigned     BYPASS   = 1,
  parameter logic [XLEN-1:0] SP_INIT  = XLEN'(rv_pkg::SP_INIT),
  parameter logic [XLEN-1:0] GP_INIT  = XLEN'(rv_pkg::GP_INIT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [XLEN-1:0]        wr_data,
  input  logic [NUM_RD*AW-1:0]   rs_addr,
  output logic [NUM_RD*XLEN-1:0] rs_data,
  output logic [NUM_RD-1:0]      rs_busy,
  input  logic                   sb_set,
  input  logic [AW-1:0]          sb_addr,
  input  logic                   sb_flush
);

  logic [XLEN-1:0] regs [NUM_REGS];

  // Every entry, including x0, is reset so no read can ever surface X.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[AW'(i)] <= '0;
      end
      regs[AW'(REG_SP)] <= SP_INIT;
      regs[AW'(REG_GP)] <= GP_INIT;
    end else if (wr_en && (wr_addr != AW'(REG_ZERO))) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Forwarding is held off during reset so reads show the reset contents.
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0] rd_addr;
    logic          fwd;

    assign rd_addr = rs_addr[i*AW +: AW];
    assign fwd     = (BYPASS != 0) && rst && wr_en && (wr_addr == rd_addr);
    assign rs_data[i*XLEN +: XLEN] = (rd_addr == AW'(REG_ZERO)) ? '0 :
                                     fwd                        ? wr_data :
                                                                  regs[rd_addr];
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .AW       (AW),
    .NUM_RD   (NUM_RD),
    .BYPASS   (BYPASS)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .sb_set   (sb_set),
    .sb_addr  (sb_addr),
    .sb_flush (sb_flush),
    .rs_addr  (rs_addr),
    .rs_busy  (rs_busy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp (3 read ports, bypass enabled): each scenario
// queues expected port values as it drives stimulus and drains them at sample time.
module tb_regfile_mp;

  localparam int unsigned XL = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [XL-1:0]     wr_data;
  logic [NR*AW-1:0]  rs_addr;
  logic [NR*XL-1:0]  rs_data;
  logic [NR-1:0]     rs_busy;
  logic              sb_set;
  logic [AW-1:0]     sb_addr;
  logic              sb_flush;

  always #5 clk = ~clk;

  regfile_mp #(
    .XLEN     (XL),
    .NUM_REGS (32),
    .AW       (AW),
    .NUM_RD   (NR),
    .BYPASS   (1),
    .SP_INIT  (32'h200),
    .GP_INIT  (32'h100)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rs_addr  (rs_addr),
    .rs_data  (rs_data),
    .rs_busy  (rs_busy),
    .sb_set   (sb_set),
    .sb_addr  (sb_addr),
    .sb_flush (sb_flush)
  );

  typedef struct {
    string       name;
    int          port;
    logic [31:0] data;
    logic        busy;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void push(input string n, input int p, input logic [31:0] d, input logic b);
    exp_t e;
    e.name = n; e.port = p; e.data = d; e.busy = b;
    sbq.push_back(e);
  endfunction

  task automatic idle();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    sb_set = 1'b0; sb_addr = '0; sb_flush = 1'b0;
  endtask

  task automatic next();
    @(posedge clk); #1;
    idle();
  endtask

  task automatic rd(input int p, input logic [AW-1:0] a);
    rs_addr[p*AW +: AW] = a;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
  endtask

  task automatic mark(input logic [AW-1:0] a);
    sb_set = 1'b1; sb_addr = a;
  endtask

  task automatic test_reset();
    exp_t e;
    @(posedge clk); #1;
    rd(0, 5'd2); rd(1, 5'd3); rd(2, 5'd5);
    push("rst_x2", 0, 32'h200, 1'b0); push("rst_x3", 1, 32'h100, 1'b0); push("rst_x5", 2, 32'h0, 1'b0);
    #3;
    while (sbq.size() != 0) begin e = sbq.pop_front(); n_cmp++;
      if ({rs_data[e.port*XL +: XL], rs_busy[e.port]} !== {e.data, e.busy}) begin n_bad++;
        $display("FAIL %s p%0d: data=%h busy=%b, expected data=%h busy=%b", e.name, e.port, rs_data[e.port*XL +: XL], rs_busy[e.port], e.data, e.busy); end end
    next(); rst = 1'b1;
    wr(5'd5, 32'hAB);
    next(); wr(5'd2, 32'h77); mark(5'd5);
    next();
    push("pre_x2", 0, 32'h77, 1'b0); push("pre_x3", 1, 32'h100, 1'b0); push("pre_x5", 2, 32'hAB, 1'b1);
    #3;
    while (sbq.size() != 0) begin e = sbq.pop_front(); n_cmp++;
      if ({rs_data[e.port*XL +: XL], rs_busy[e.port]} !== {e.data, e.busy}) begin n_bad++;
        $display("FAIL %s p%0d: data=%h busy=%b, expected data=%h busy=%b", e.name, e.port, rs_data[e.port*XL +: XL], rs_busy[e.port], e.data, e.busy); end end
    // reset lands between edges while a write to x3 is on the bus
    next(); wr(5'd3, 32'h99);
    #1; rst = 1'b0;
    #2;
    push("async_x2", 0, 32'h200, 1'b0); push("async_x3", 1, 32'h100, 1'b0); push("async_x5", 2, 32'h0, 1'b0);
    while (sbq.size() != 0) begin e = sbq.pop_front(); n_cmp++;
      if ({rs_data[e.port*XL +: XL], rs_busy[e.port]} !== {e.data, e.busy}) begin n_bad++;
        $display("FAIL %s p%0d: data=%h busy=%b, expected data=%h busy=%b", e.name, e.port, rs_data[e.port*XL +: XL], rs_busy[e.port], e.data, e.busy); end end
    @(posedge clk); #1;
    push("held_x2", 0, 32'h200, 1'b0); push("held_x3", 1, 32'h100, 1'b0); push("held_x5", 2, 32'h0, 1'b0);
    #3;
    while (sbq.size() != 0) begin e = sbq.pop_front(); n_cmp++;
      if ({rs_data[e.port*XL +: XL], rs_busy[e.port]} !== {e.data, e.busy}) begin n_bad++;
        $display("FAIL %s p%0d: data=%h busy=%b, expected data=%h busy=%b", e.name, e.port, rs_data[e.port*XL +: XL], rs_busy[e.port], e.data, e.busy); end end
    next(); rst = 1'b1;
  endtask

  task automatic test_x0();
    exp_t e;
    next(); wr(5'd0, 32'hDEADBEEF); mark(5'd0);
    for (int p = 0; p < int'(NR); p++) begin rd(p, 5'd0); push("x0_same", p, 32'h0, 1'b0); end
    #3;
    while (sbq.size() != 0) begin e = sbq.pop_front(); n_cmp++;
      if ({rs_data[e.port*XL +: XL], rs_busy[e.port]} !== {e.data, e.busy}) begin n_bad++;
        $display("FAIL %s p%0d: data=%h busy=%b, expected data=%h busy=%b", e.name, e.port, rs_data[e.port*XL +: XL], rs_busy[e.port], e.data, e.busy); end end
    next();
    for (int p = 0; p < int'(NR); p++) push("x0_after", p, 32'h0, 1'b0);
    #3;
    while (sbq.size() != 0) begin e = sbq.pop_front(); n_cmp++;
      if ({rs_data[e.port*XL +: XL], rs_busy[e.port]} !== {e.data, e.busy}) begin n_bad++;
        $display("FAIL %s p%0d: data=%h busy=%b, expected data=%h busy=%b", e.name, e.port, rs_data[e.port*XL +: XL], rs_busy[e.port], e.data, e.busy); end end
  endtask

  task automatic test_bypass();
    exp_t e;
    next(); wr(5'd7, 32'h11);
    rd(0, 5'd7); rd(1, 5'd7); rd(2, 5'd2);
    next(); wr(5'd7, 32'h55);
    push("byp_p0", 0, 32'h55, 1'b0); push("byp_p1", 1, 32'h55, 1'b0); push("byp_x2", 2, 32'h200, 1'b0);
    #3;
    while (sbq.size() != 0) begin e = sbq.pop_front(); n_cmp++;
      if ({rs_data[e.port*XL +: XL], rs_busy[e.port]} !== {e.data, e.busy}) begin n_bad++;
        $display("FAIL %s p%0d: data=%h busy=%b, expected data=%h busy=%b", e.name, e.port, rs_data[e.port*XL +: XL], rs_busy[e.port], e.data, e.busy); end end
    next();
    push("byp_held0", 0, 32'h55, 1'b0); push("byp_held1", 1, 32'h55, 1'b0);
    #3;
    while (sbq.size() != 0) begin e = sbq.pop_front(); n_cmp++;
      if ({rs_data[e.port*XL +: XL], rs_busy[e.port]} !== {e.data, e.busy}) begin n_bad++;
        $display("FAIL %s p%0d: data=%h busy=%b, expected data=%h busy=%b", e.name, e.port, rs_data[e.port*XL +: XL], rs_busy[e.port], e.data, e.busy); end end
  endtask

  task automatic test_scoreboard();
    exp_t e;
    next(); mark(5'd9);
    rd(0, 5'd9); rd(1, 5'd9); rd(2, 5'd9);
    push("sb_issue", 0, 32'h0, 1'b0);
    #3;
    while (sbq.size() != 0) begin e = sbq.pop_front(); n_cmp++;
      if ({rs_data[e.port*XL +: XL], rs_busy[e.port]} !== {e.data, e.busy}) begin n_bad++;
        $display("FAIL %s p%0d: data=%h busy=%b, expected data=%h busy=%b", e.name, e.port, rs_data[e.port*XL +: XL], rs_busy[e.port], e.data, e.busy); end end
    for (int c = 0; c < 3; c++) begin
      next();
      push("sb_wait0", 0, 32'h0, 1'b1); push("sb_wait1", 1, 32'h0, 1'b1);
      #3;
      while (sbq.size() != 0) begin e = sbq.pop_front(); n_cmp++;
        if ({rs_data[e.port*XL +: XL], rs_busy[e.port]} !== {e.data, e.busy}) begin n_bad++;
          $display("FAIL %s p%0d: data=%h busy=%b, expected data=%h busy=%b", e.name, e.port, rs_data[e.port*XL +: XL], rs_busy[e.port], e.data, e.busy); end end
    end
    next(); wr(5'd9, 32'h900);
    push("sb_wb0", 0, 32'h900, 1'b0); push("sb_wb2", 2, 32'h900, 1'b0);
    #3;
    while (sbq.size() != 0) begin e = sbq.pop_front(); n_cmp++;
      if ({rs_data[e.port*XL +: XL], rs_busy[e.port]} !== {e.data, e.busy}) begin n_bad++;
        $display("FAIL %s p%0d: data=%h busy=%b, expected data=%h busy=%b", e.name, e.port, rs_data[e.port*XL +: XL], rs_busy[e.port], e.data, e.busy); end end
    next();
    push("sb_retired", 0, 32'h900, 1'b0);
    #3;
    while (sbq.size() != 0) begin e = sbq.pop_front(); n_cmp++;
      if ({rs_data[e.port*XL +: XL], rs_busy[e.port]} !== {e.data, e.busy}) begin n_bad++;
        $display("FAIL %s p%0d: data=%h busy=%b, expected data=%h busy=%b", e.name, e.port, rs_data[e.port*XL +: XL], rs_busy[e.port], e.data, e.busy); end end
  endtask

  task automatic test_simultaneous();
    exp_t e;
    next(); mark(5'd4); wr(5'd4, 32'h44);
    rd(0, 5'd4); rd(1, 5'd6); rd(2, 5'd4);
    next();
    push("same_set_wins", 0, 32'h44, 1'b1); push("same_x6_idle", 1, 32'h0, 1'b0);
    #3;
    while (sbq.size() != 0) begin e = sbq.pop_front(); n_cmp++;
      if ({rs_data[e.port*XL +: XL], rs_busy[e.port]} !== {e.data, e.busy}) begin n_bad++;
        $display("FAIL %s p%0d: data=%h busy=%b, expected data=%h busy=%b", e.name, e.port, rs_data[e.port*XL +: XL], rs_busy[e.port], e.data, e.busy); end end
    next(); wr(5'd4, 32'h46); mark(5'd6);
    next(); mark(5'd4); wr(5'd6, 32'h66);
    push("diff_x4_now", 0, 32'h46, 1'b0); push("diff_x6_fwd", 1, 32'h66, 1'b0);
    #3;
    while (sbq.size() != 0) begin e = sbq.pop_front(); n_cmp++;
      if ({rs_data[e.port*XL +: XL], rs_busy[e.port]} !== {e.data, e.busy}) begin n_bad++;
        $display("FAIL %s p%0d: data=%h busy=%b, expected data=%h busy=%b", e.name, e.port, rs_data[e.port*XL +: XL], rs_busy[e.port], e.data, e.busy); end end
    next();
    push("diff_x4_set", 0, 32'h46, 1'b1); push("diff_x6_clr", 1, 32'h66, 1'b0);
    #3;
    while (sbq.size() != 0) begin e = sbq.pop_front(); n_cmp++;
      if ({rs_data[e.port*XL +: XL], rs_busy[e.port]} !== {e.data, e.busy}) begin n_bad++;
        $display("FAIL %s p%0d: data=%h busy=%b, expected data=%h busy=%b", e.name, e.port, rs_data[e.port*XL +: XL], rs_busy[e.port], e.data, e.busy); end end
  endtask

  task automatic test_flush();
    exp_t e;
    next(); mark(5'd1); wr(5'd31, 32'h3131);
    next(); mark(5'd8);
    next(); mark(5'd31);
    next();
    rd(0, 5'd1); rd(1, 5'd8); rd(2, 5'd31);
    push("fl_pend_x1", 0, 32'h0, 1'b1); push("fl_pend_x8", 1, 32'h0, 1'b1); push("fl_pend_x31", 2, 32'h3131, 1'b1);
    #3;
    while (sbq.size() != 0) begin e = sbq.pop_front(); n_cmp++;
      if ({rs_data[e.port*XL +: XL], rs_busy[e.port]} !== {e.data, e.busy}) begin n_bad++;
        $display("FAIL %s p%0d: data=%h busy=%b, expected data=%h busy=%b", e.name, e.port, rs_data[e.port*XL +: XL], rs_busy[e.port], e.data, e.busy); end end
    next(); sb_flush = 1'b1; mark(5'd10);
    push("fl_cyc_x1", 0, 32'h0, 1'b1); push("fl_cyc_x8", 1, 32'h0, 1'b1); push("fl_cyc_x31", 2, 32'h3131, 1'b1);
    #3;
    while (sbq.size() != 0) begin e = sbq.pop_front(); n_cmp++;
      if ({rs_data[e.port*XL +: XL], rs_busy[e.port]} !== {e.data, e.busy}) begin n_bad++;
        $display("FAIL %s p%0d: data=%h busy=%b, expected data=%h busy=%b", e.name, e.port, rs_data[e.port*XL +: XL], rs_busy[e.port], e.data, e.busy); end end
    next();
    push("fl_done_x1", 0, 32'h0, 1'b0); push("fl_done_x8", 1, 32'h0, 1'b0); push("fl_done_x31", 2, 32'h3131, 1'b0);
    #3;
    while (sbq.size() != 0) begin e = sbq.pop_front(); n_cmp++;
      if ({rs_data[e.port*XL +: XL], rs_busy[e.port]} !== {e.data, e.busy}) begin n_bad++;
        $display("FAIL %s p%0d: data=%h busy=%b, expected data=%h busy=%b", e.name, e.port, rs_data[e.port*XL +: XL], rs_busy[e.port], e.data, e.busy); end end
    rd(0, 5'd10); rd(1, 5'd7); rd(2, 5'd2);
    push("fl_x10_blocked", 0, 32'h0, 1'b0); push("fl_x7_kept", 1, 32'h55, 1'b0); push("fl_x2_kept", 2, 32'h200, 1'b0);
    #1;
    while (sbq.size() != 0) begin e = sbq.pop_front(); n_cmp++;
      if ({rs_data[e.port*XL +: XL], rs_busy[e.port]} !== {e.data, e.busy}) begin n_bad++;
        $display("FAIL %s p%0d: data=%h busy=%b, expected data=%h busy=%b", e.name, e.port, rs_data[e.port*XL +: XL], rs_busy[e.port], e.data, e.busy); end end
  endtask

  initial begin
    rst = 1'b0;
    rs_addr = '0;
    idle();
    test_reset();
    test_x0();
    test_bypass();
    test_scoreboard();
    test_simultaneous();
    test_flush();
    next();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
